hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Pipeline-control block beside the EX stage of the five-stage MIPS core. It shadows the destination-register bookkeeping of the EX, MEM and WB stages and produces the 2-bit operand-select codes for the two EX-stage 3-to-1 operand multiplexers (ALU inputs A and B). It also detects load-use hazards and stalls the front end for exactly one cycle while inserting a bubble. Branch flushes and saturating stall/flush counters are handled here too.

## Interface
- `REG_ADDR_W`, 5: register-number width.
- `CNT_W`, 16: width of each performance counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  REG_ADDR_W  source registers of the ID instruction.
- `id_dest`  in  REG_ADDR_W  final destination (rt/rd/31 already resolved).
- `id_regwrite`, `id_memread`  in  1  ID instruction writes the register file / is a load.
- `flush`  in  1  branch/jump taken; kill the ID instruction.
- `forward_a`, `forward_b`  out  2  operand selects. 0 = ID/EX register value, 1 = MEM/WB writeback data, 2 = EX/MEM ALU result. 3 is never driven.
- `stall`  out  1  load-use stall this cycle.
- `pc_we`, `ifid_we`  out  1  equal to `~stall`.
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters.

## Operation
- Internal shadow pipeline, one slot per stage: EX{rs, rt, dest, regwrite, memread}, MEM{dest, regwrite}, WB{dest, regwrite}.
- Each cycle the slots advance: MEM←EX, WB←MEM.
- EX loads the ID fields when `id_valid & ~stall & ~flush`. Otherwise EX loads a bubble: regwrite=0, memread=0, all register fields 0.
- Forward A select, decoded from EX.rs (B is identical, using EX.rt):
  - 2 if MEM.regwrite, MEM.dest≠0 and MEM.dest==EX.rs.
  - Otherwise 1 if WB.regwrite, WB.dest≠0 and WB.dest==EX.rs.
  - Otherwise 0.
  - When both MEM and WB match, the MEM stage (newer value) wins.
- Register 0 is never forwarded.
- Load-use stall is asserted when all of the following hold:
  - `id_valid` and EX.memread;
  - EX.dest≠0;
  - EX.dest==`id_rs` or EX.dest==`id_rt`.
- `flush` has priority over the stall: when `flush`=1, `stall`=0 and a bubble enters EX.
- A stall lasts exactly one cycle. After it, the load has moved to MEM, so the repeated ID instruction no longer matches EX and is forwarded from WB one cycle later.
- Counters:
  - `stall_cnt` increments on each stall cycle.
  - `flush_cnt` increments on each `flush` cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- `forward_a`/`forward_b` are decoded only from shadow registers, with no combinational path from inputs. They are valid early in the cycle.
- `stall`, `pc_we` and `ifid_we` are combinational from the ID inputs and EX state, in the same cycle.
- A bubble appears in EX one edge after the stall or flush cycle.
- Counters update on the edge that ends the event cycle, so they are visible the following cycle.
- Reset values:
  - All slots are bubbles.
  - `forward_a`=`forward_b`=0.
  - `stall`=0, `pc_we`=`ifid_we`=1.
  - Both counters are 0.
- Reset asserted mid-stall clears all state immediately. No pending stall survives it.

## Structure
- Shared package `hazard_pkg` holds:
  - constants `FWD_RF`=0, `FWD_WB`=1, `FWD_MEM`=2;
  - the shadow-slot struct/typedef.
- One natural sub-module, `forward_select`: the purely combinational priority compare for a single operand, instantiated twice (A and B).
- The counters are written inline.

## Test plan
- **EX/MEM forward.** `add $3,$1,$2` then `sub $4,$3,$5`, one cycle apart → `forward_a`=2 while sub is in EX; `forward_b`=0.
- **MEM/WB forward and priority.**
  - `add $3`, then nop, then `or $6,$7,$3` → `forward_b`=1.
  - With `$3` written by both MEM and WB → `forward_b`=2.
- **Register zero.** Writer with dest=0, followed by a reader of `$0` → both selects stay 0.
- **Load-use.**
  - `lw $8,0($9)` then `add $10,$8,$8` → `stall`=1 for exactly one cycle and `pc_we`=0.
  - A bubble then occupies EX.
  - `forward_a`=`forward_b`=1 in the following EX cycle.
  - `stall_cnt`=1.
- **Flush during load-use.** Same load-use condition with `flush`=1 → `stall`=0, bubble enters EX, `flush_cnt` increments.
- **Saturation and reset.**
  - Preload `stall_cnt` near 16'hFFFF via repeated load-use pairs → it stays at 16'hFFFF.
  - Assert `rst` mid-stall → all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX-stage hazard/forwarding unit.
package hazard_pkg;

  localparam int REG_AW = 5;

  // Operand-select codes for the EX-stage 3-to-1 operand multiplexers
  localparam logic [1:0] FWD_RF  = 2'd0;  // ID/EX register value
  localparam logic [1:0] FWD_WB  = 2'd1;  // MEM/WB writeback data
  localparam logic [1:0] FWD_MEM = 2'd2;  // EX/MEM ALU result

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Shadow of the instruction currently in EX
  typedef struct packed {
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t dest;
    logic      regwrite;
    logic      memread;
  } ex_slot_t;

  // Shadow of the instruction in MEM or WB; only the write target matters
  typedef struct packed {
    reg_addr_t dest;
    logic      regwrite;
  } wr_slot_t;

endpackage

// File: rtl/hazard_forward_unit_forward_select.sv
// Priority compare for one EX operand: the newest in-flight writer wins,
// and register 0 is never forwarded because it is hardwired to zero.
module forward_select
  import hazard_pkg::*;
#(
  parameter int W = REG_AW
) (
  input  logic [W-1:0] src,
  input  logic [W-1:0] mem_dest,
  input  logic         mem_regwrite,
  input  logic [W-1:0] wb_dest,
  input  logic         wb_regwrite,
  output logic [1:0]   sel
);

  // MEM is checked first so it overrides an older WB match
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_dest != '0) && (mem_dest == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_dest != '0) && (wb_dest == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control beside the EX stage: shadows destination
// bookkeeping of EX/MEM/WB, selects operand sources, raises a one-cycle
// load-use stall, and counts stall and flush events.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_AW,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  ex_slot_t          ex_q, ex_d;
  wr_slot_t          mem_q, mem_d;
  wr_slot_t          wb_q, wb_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use;
  logic              stall_int;

  // Load in EX feeding the ID instruction; a taken branch kills ID instead
  always_comb begin
    load_use  = id_valid && ex_q.memread && (ex_q.dest != '0) &&
                ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));
    stall_int = load_use && !flush;
  end

  // Advance the shadow pipeline; stalls and flushes inject a bubble into EX
  always_comb begin
    ex_d = '0;
    if (id_valid && !stall_int && !flush) begin
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.dest     = id_dest;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
    mem_d.dest     = ex_q.dest;
    mem_d.regwrite = ex_q.regwrite;
    wb_d           = mem_q;
  end

  // Saturating event counters, held at all-ones once reached
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))     flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers; reset empties every slot and clears the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  forward_select #(.W(REG_ADDR_W)) u_fwd_a (
    .src          (ex_q.rs),
    .mem_dest     (mem_q.dest),
    .mem_regwrite (mem_q.regwrite),
    .wb_dest      (wb_q.dest),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (forward_a)
  );

  forward_select #(.W(REG_ADDR_W)) u_fwd_b (
    .src          (ex_q.rt),
    .mem_dest     (mem_q.dest),
    .mem_regwrite (mem_q.regwrite),
    .wb_dest      (wb_q.dest),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (forward_b)
  );

  assign stall     = stall_int;
  assign pc_we     = !stall_int;
  assign ifid_we   = !stall_int;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed program fragments plus random
// instruction streams, compared every cycle against a history-based model.
// A second instance with 4-bit counters exercises saturation quickly.
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_regwrite, id_memread, flush;

  logic [1:0]  forward_a, forward_b;
  logic        stall, pc_we, ifid_we;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_forward_a, s_forward_b;
  logic        s_stall, s_pc_we, s_ifid_we;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per-age history of what entered EX (0 = in EX, 1 = MEM, 2 = WB)
  int m_rs[3], m_rt[3], m_dest[3], m_rw[3], m_mr[3];
  int m_sc, m_fc, m_ssc, m_sfc;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .pc_we(pc_we), .ifid_we(ifid_we), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_forward_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .forward_a(s_forward_a), .forward_b(s_forward_b), .stall(s_stall),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input int src);
    // Youngest older instruction writing a nonzero matching register wins
    for (int age = 1; age <= 2; age++)
      if (m_rw[age] != 0 && m_dest[age] != 0 && m_dest[age] == src)
        return (age == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic int exp_stall();
    if (flush || !id_valid || m_mr[0] == 0 || m_dest[0] == 0) return 0;
    return (m_dest[0] == int'(id_rs) || m_dest[0] == int'(id_rt)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rs[i] = 0; m_rt[i] = 0; m_dest[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
    end
    m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input int dest,
                       input bit rw, input bit mr, input bit fl);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_dest     = 5'(dest);
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
  endtask

  // Mid-cycle comparison of every output against the model
  task automatic mid();
    int s;
    @(negedge clk);
    s = exp_stall();
    chk("forward_a", int'(forward_a), exp_fwd(m_rs[0]));
    chk("forward_b", int'(forward_b), exp_fwd(m_rt[0]));
    chk("stall", int'(stall), s);
    chk("pc_we", int'(pc_we), 1 - s);
    chk("ifid_we", int'(ifid_we), 1 - s);
    chk("stall_cnt", int'(stall_cnt), m_sc);
    chk("flush_cnt", int'(flush_cnt), m_fc);
    chk("small_stall_cnt", int'(s_stall_cnt), m_ssc);
    chk("small_flush_cnt", int'(s_flush_cnt), m_sfc);
  endtask

  task automatic edge_();
    int s;
    @(posedge clk);
    s = exp_stall();
    for (int i = 2; i > 0; i--) begin
      m_rs[i] = m_rs[i-1]; m_rt[i] = m_rt[i-1]; m_dest[i] = m_dest[i-1];
      m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
    end
    if (id_valid && s == 0 && !flush) begin
      m_rs[0] = id_rs; m_rt[0] = id_rt; m_dest[0] = id_dest;
      m_rw[0] = id_regwrite; m_mr[0] = id_memread;
    end else begin
      m_rs[0] = 0; m_rt[0] = 0; m_dest[0] = 0; m_rw[0] = 0; m_mr[0] = 0;
    end
    if (s != 0) begin
      if (m_sc < 65535) m_sc++;
      if (m_ssc < 15) m_ssc++;
    end
    if (flush) begin
      if (m_fc < 65535) m_fc++;
      if (m_sfc < 15) m_sfc++;
    end
    #1;
  endtask

  task automatic cyc(input bit v, input int rs, input int rt, input int dest,
                     input bit rw, input bit mr, input bit fl);
    drive(v, rs, rt, dest, rw, mr, fl);
    mid();
    edge_();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_forward_a"}, int'(forward_a), 0);
    chk({tag, "_forward_b"}, int'(forward_b), 0);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_pc_we"}, int'(pc_we), 1);
    chk({tag, "_ifid_we"}, int'(ifid_we), 1);
    chk({tag, "_stall_cnt"}, int'(stall_cnt), 0);
    chk({tag, "_flush_cnt"}, int'(flush_cnt), 0);
    chk({tag, "_small_stall_cnt"}, int'(s_stall_cnt), 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // EX/MEM forward: add $3,$1,$2 ; sub $4,$3,$5
    cyc(1, 1, 2, 3, 1, 0, 0);
    cyc(1, 3, 5, 4, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("exmem_fwd_a", int'(forward_a), 2);
    chk("exmem_fwd_b", int'(forward_b), 0);
    edge_();

    // MEM/WB forward: add $3 ; nop ; or $6,$7,$3
    cyc(1, 1, 2, 3, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 3, 6, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("memwb_fwd_b", int'(forward_b), 1);
    chk("memwb_fwd_a", int'(forward_a), 0);
    edge_();

    // Both MEM and WB write $3: newer one wins
    cyc(1, 1, 2, 3, 1, 0, 0);
    cyc(1, 1, 2, 3, 1, 0, 0);
    cyc(1, 7, 3, 6, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("priority_fwd_b", int'(forward_b), 2);
    edge_();

    // Register zero writer followed by $0 reader
    cyc(1, 1, 2, 0, 1, 0, 0);
    cyc(1, 0, 0, 5, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("zero_fwd_a", int'(forward_a), 0);
    chk("zero_fwd_b", int'(forward_b), 0);
    edge_();

    // Load-use: lw $8,0($9) ; add $10,$8,$8
    cyc(1, 9, 8, 8, 1, 1, 0);
    drive(1, 8, 8, 10, 1, 0, 0);
    mid();
    chk("lu_stall", int'(stall), 1);
    chk("lu_pc_we", int'(pc_we), 0);
    chk("lu_ifid_we", int'(ifid_we), 0);
    chk("lu_cnt_before", int'(stall_cnt), 0);
    edge_();
    drive(1, 8, 8, 10, 1, 0, 0);
    mid();
    chk("lu_stall_once", int'(stall), 0);
    chk("lu_bubble_fwd_a", int'(forward_a), 0);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    edge_();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("lu_fwd_a_wb", int'(forward_a), 1);
    chk("lu_fwd_b_wb", int'(forward_b), 1);
    edge_();

    // Flush during load-use
    cyc(1, 9, 8, 8, 1, 1, 0);
    drive(1, 8, 8, 10, 1, 0, 1);
    mid();
    chk("fl_stall", int'(stall), 0);
    chk("fl_pc_we", int'(pc_we), 1);
    edge_();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("fl_flush_cnt", int'(flush_cnt), 1);
    chk("fl_stall_cnt", int'(stall_cnt), 1);
    chk("fl_bubble_fwd_a", int'(forward_a), 0);
    edge_();

    // Random streams over a small register set to provoke many hazards
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0);
    end
    chk("small_stall_sat", int'(s_stall_cnt), 15);
    chk("small_flush_sat", int'(s_flush_cnt), 15);

    // Reset asserted in the middle of a stall cycle
    cyc(1, 9, 8, 8, 1, 1, 0);
    drive(1, 8, 8, 10, 1, 0, 0);
    mid();
    chk("rst_pre_stall", int'(stall), 1);
    #1 rst = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 200; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
